// File: rtl/early_debounce_ctrl.sv
// Early-detect multi-channel debouncer: output follows the first edge, then ignores bounces for a tick-timed lockout.
// Latency sw_in->db_out is 3 clk edges; no backpressure. Optional EDGE_PULSE_EN adds rise_p/fall_p pulses.
module early_debounce_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int M          = 100000,
    parameter int WAIT_TICKS = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] busy,
    output logic              tick
`ifdef EDGE_PULSE_EN
    ,
    output logic [NUM_CH-1:0] rise_p,
    output logic [NUM_CH-1:0] fall_p
`endif
);

    localparam int PW = $clog2(M);
    localparam int CW = $clog2(WAIT_TICKS + 1);
    localparam logic [PW-1:0] P_LAST  = PW'(M - 1);
    localparam logic [CW-1:0] CNT_LD  = CW'(WAIT_TICKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    logic [PW-1:0]     pcnt;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sw_s;
    logic [NUM_CH-1:0] db_nxt;
    logic [NUM_CH-1:0] busy_nxt;

    // Free-running prescaler shared by all channels; it never pauses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
        end else if (pcnt == P_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = (pcnt == P_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sw_s  <= '0;
        end else begin
            sync1 <= sw_in;
            sw_s  <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= ZERO;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // A tick in the cycle that enters WAIT* is ignored because the load wins.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ZERO: begin
                    if (sw_s[g]) begin
                        state_nxt = WAIT1;
                        cnt_nxt   = CNT_LD;
                    end
                end
                WAIT1: begin
                    if (tick) begin
                        if (cnt == CNT_ONE) state_nxt = ONE;
                        else                cnt_nxt   = cnt - CNT_ONE;
                    end
                end
                ONE: begin
                    if (!sw_s[g]) begin
                        state_nxt = WAIT0;
                        cnt_nxt   = CNT_LD;
                    end
                end
                WAIT0: begin
                    if (tick) begin
                        if (cnt == CNT_ONE) state_nxt = ZERO;
                        else                cnt_nxt   = cnt - CNT_ONE;
                    end
                end
                default: state_nxt = ZERO;
            endcase
        end

        assign db_nxt[g]   = (state_nxt == WAIT1) || (state_nxt == ONE);
        assign busy_nxt[g] = (state_nxt == WAIT1) || (state_nxt == WAIT0);
    end

    // Outputs registered from next state so they move on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_out <= '0;
            busy   <= '0;
        end else begin
            db_out <= db_nxt;
            busy   <= busy_nxt;
        end
    end

`ifdef EDGE_PULSE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_p <= '0;
            fall_p <= '0;
        end else begin
            rise_p <= db_nxt & ~db_out;
            fall_p <= ~db_nxt & db_out;
        end
    end
`endif

endmodule

// File: tb/tb_early_debounce_ctrl.sv
// Directed bench for early_debounce_ctrl with NUM_CH=2, M=4, WAIT_TICKS=3.
module tb_early_debounce_ctrl;

    logic       clk;
    logic       reset_n;
    logic [1:0] sw_in;
    logic [1:0] db_out;
    logic [1:0] busy;
    logic       tick;
`ifdef EDGE_PULSE_EN
    logic [1:0] rise_p;
    logic [1:0] fall_p;
`endif

    int n_chk = 0;
    int n_err = 0;

    early_debounce_ctrl #(
        .NUM_CH    (2),
        .M         (4),
        .WAIT_TICKS(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw_in  (sw_in),
        .db_out (db_out),
        .busy   (busy),
        .tick   (tick)
`ifdef EDGE_PULSE_EN
        ,
        .rise_p (rise_p),
        .fall_p (fall_p)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that released reset (cycle index 0).
    task automatic do_reset();
        reset_n = 1'b0;
        sw_in   = 2'b00;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sw_in   = 2'b11;
        step();
        step();
        step();
        chk("rst_db",   32'(db_out), 32'd0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_tick", 32'(tick),   32'd0);

        // Tests 1+2: both inputs high through release; tick phase and 3-edge latency.
        reset_n = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            step();
            chk($sformatf("t1_tick_%0d", j), 32'(tick),   32'((j % 4) == 3));
            chk($sformatf("t1_db_%0d", j),   32'(db_out), (j >= 3) ? 32'd3 : 32'd0);
            chk($sformatf("t1_busy_%0d", j), 32'(busy),   (j >= 3 && j <= 11) ? 32'd3 : 32'd0);
        end

        // Test 3: ch0 bounces inside the lockout, then settles high.
        do_reset();
        for (int j = 0; j <= 26; j++) begin
            if (j > 0) step();
            chk($sformatf("t3_db0_%0d", j),   32'(db_out[0]), 32'(j >= 3));
            chk($sformatf("t3_busy0_%0d", j), 32'(busy[0]),   32'(j >= 3 && j <= 11));
            chk($sformatf("t3_db1_%0d", j),   32'(db_out[1]), 32'd0);
            sw_in[0] = (j >= 8 || ((j / 2) % 2) == 0) ? 1'b1 : 1'b0;
        end

        // Test 4 (and 6): one-cycle pulse on ch1 stretched to a full lockout, then a second lockout.
        do_reset();
        for (int j = 0; j <= 28; j++) begin
            if (j > 0) step();
            chk($sformatf("t4_db1_%0d", j),   32'(db_out[1]), 32'(j >= 3 && j <= 12));
            chk($sformatf("t4_busy1_%0d", j), 32'(busy[1]),
                32'((j >= 3 && j <= 11) || (j >= 13 && j <= 23)));
            chk($sformatf("t4_db0_%0d", j),   32'(db_out[0]), 32'd0);
`ifdef EDGE_PULSE_EN
            chk($sformatf("t6_rise_%0d", j), 32'(rise_p), (j == 3)  ? 32'd2 : 32'd0);
            chk($sformatf("t6_fall_%0d", j), 32'(fall_p), (j == 13) ? 32'd2 : 32'd0);
`endif
            sw_in[1] = (j == 0) ? 1'b1 : 1'b0;
        end

        // Test 5: asynchronous reset in the middle of ch0 lockout, then retrigger.
        do_reset();
        sw_in[0] = 1'b1;
        for (int j = 1; j <= 5; j++) step();
        chk("t5_pre_db0",   32'(db_out[0]), 32'd1);
        chk("t5_pre_busy0", 32'(busy[0]),   32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_db",   32'(db_out), 32'd0);
        chk("t5_rst_busy", 32'(busy),   32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("t5_e2_db0", 32'(db_out[0]), 32'd0);
        step();
        chk("t5_e3_db0",   32'(db_out[0]), 32'd1);
        chk("t5_e3_busy0", 32'(busy[0]),   32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
